// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the stream packing FIFO.
//   state_t    : write-side admission state (PASS accepts beats, DROP discards
//                them until a packet boundary with room to resume).
//   addr_width : address width needed to index a memory of the given depth.
package fifo_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram
// Single-clock simple dual-port memory with one write port and one
// registered read port. Contents are not cleared by reset.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata updates on the next edge, holds otherwise
//   raddr : read address
//   rdata : registered read data
module sdp_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_pack_fifo.sv
// stream_pack_fifo
// Packs narrow input beats into wide words (first beat in the MSBs) and
// buffers them in a show-ahead FIFO. Writes are never stalled: when a word
// cannot be stored the block enters DROP and discards beats until a packet
// end arrives with the FIFO drained to RESUME_LEVEL or below.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wr_tdata   : input beat
//   wr_tvalid  : beat present, always consumed
//   wr_tlast   : last beat of a packet (forces a commit)
//   wr_tready  : advisory, high in PASS with at least READY_MARGIN free words
//   rd_tdata   : head word (zero while rd_tvalid is low)
//   rd_tvalid  : head word valid
//   rd_tready  : pop head word
//   rd_tlast   : head word ends a packet
//   rd_sample  : capture {recovery flag, level MSBs} into rd_status
//   rd_status  : last captured status
//   level      : words stored and not yet popped
module stream_pack_fifo
  import fifo_pkg::*;
#(
  parameter int WR_WIDTH     = 8,
  parameter int RATIO        = 4,
  parameter int DEPTH        = 1024,
  parameter int RESUME_LEVEL = DEPTH / 4,
  parameter int READY_MARGIN = 8,
  parameter int STATUS_BITS  = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WR_WIDTH-1:0]            wr_tdata,
  input  logic                           wr_tvalid,
  input  logic                           wr_tlast,
  output logic                           wr_tready,
  output logic [WR_WIDTH*RATIO-1:0]      rd_tdata,
  output logic                           rd_tvalid,
  input  logic                           rd_tready,
  output logic                           rd_tlast,
  input  logic                           rd_sample,
  output logic [STATUS_BITS:0]           rd_status,
  output logic [addr_width(DEPTH):0]     level
);

  localparam int RD_WIDTH = WR_WIDTH * RATIO;
  localparam int AW       = addr_width(DEPTH);
  localparam int LW       = AW + 1;
  localparam int CW       = addr_width(RATIO);
  // Level is left-aligned into a field at least STATUS_BITS wide so the
  // status always reports the most significant level bits.
  localparam int SW       = (LW > STATUS_BITS) ? LW : STATUS_BITS;

  state_t              state;
  logic [RD_WIDTH-1:0] pack_reg;
  logic [RD_WIDTH-1:0] pack_word;
  logic [CW-1:0]       pack_cnt;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       stored;
  logic                out_valid;
  logic [RD_WIDTH:0]   ram_q;
  logic                commit;
  logic                commit_ok;
  logic                pop;
  logic                fetch;
  logic                flag;

  // Current beat merged into the pack register; LSBs below it stay zero,
  // which provides the padding for a packet that ends mid-word.
  assign pack_word = pack_reg
                   | (RD_WIDTH'(wr_tdata) << (WR_WIDTH * (RATIO - 1 - int'(pack_cnt))));

  assign pop       = out_valid & rd_tready;
  assign commit    = wr_tvalid & (state == PASS)
                   & (wr_tlast | (pack_cnt == CW'(RATIO - 1)));
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign commit_ok = commit & ((level < LW'(DEPTH)) | pop);
  // The output register is refilled whenever it is empty or being popped.
  assign fetch     = (stored != '0) & (~out_valid | pop);

  assign wr_tready = (state == PASS) & (level <= LW'(DEPTH - READY_MARGIN));
  assign rd_tvalid = out_valid;
  assign rd_tdata  = out_valid ? ram_q[RD_WIDTH-1:0] : '0;
  assign rd_tlast  = out_valid & ram_q[RD_WIDTH];

  // Beat packing and the PASS/DROP admission state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PASS;
      pack_reg <= '0;
      pack_cnt <= '0;
    end else if (wr_tvalid) begin
      if (state == PASS) begin
        if (commit) begin
          pack_reg <= '0;
          pack_cnt <= '0;
          if (!commit_ok) state <= DROP;
        end else begin
          pack_reg <= pack_word;
          pack_cnt <= pack_cnt + CW'(1);
        end
      end else if (wr_tlast && (level <= LW'(RESUME_LEVEL))) begin
        state <= PASS;
      end
    end
  end

  // Pointers and occupancy. 'stored' counts words still in RAM; 'level'
  // also includes the word held in the show-ahead output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      stored    <= '0;
      out_valid <= 1'b0;
      level     <= '0;
    end else begin
      if (commit_ok) wr_ptr <= wr_ptr + AW'(1);
      if (fetch) rd_ptr <= rd_ptr + AW'(1);
      stored <= stored + LW'(commit_ok) - LW'(fetch);
      level  <= level + LW'(commit_ok) - LW'(pop);
      if (fetch) out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
    end
  end

  // Recovery flag records any underrun or drop since the last sample; a
  // sample wins over a same-cycle set so no event is counted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag      <= 1'b0;
      rd_status <= '0;
    end else if (rd_sample) begin
      flag      <= 1'b0;
      rd_status <= {flag, STATUS_BITS'((SW'(level) << (SW - LW)) >> (SW - STATUS_BITS))};
    end else if (!out_valid || (state == DROP)) begin
      flag <= 1'b1;
    end
  end

  sdp_ram #(
    .WIDTH(RD_WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (commit_ok),
    .waddr(wr_ptr),
    .wdata({wr_tlast, pack_word}),
    .re   (fetch),
    .raddr(rd_ptr),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_stream_pack_fifo.sv
// tb_stream_pack_fifo
// Bench for stream_pack_fifo with WR_WIDTH=8, RATIO=4, DEPTH=16,
// RESUME_LEVEL=4, READY_MARGIN=2. Expected words are queued as they are
// written and compared as the DUT pops them.
module tb_stream_pack_fifo;

  logic        clk;
  logic        rst;
  logic [7:0]  wr_tdata;
  logic        wr_tvalid;
  logic        wr_tlast;
  logic        wr_tready;
  logic [31:0] rd_tdata;
  logic        rd_tvalid;
  logic        rd_tready;
  logic        rd_tlast;
  logic        rd_sample;
  logic [7:0]  rd_status;
  logic [4:0]  level;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_word;

  stream_pack_fifo #(
    .WR_WIDTH(8),
    .RATIO(4),
    .DEPTH(16),
    .RESUME_LEVEL(4),
    .READY_MARGIN(2),
    .STATUS_BITS(7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_tdata (wr_tdata),
    .wr_tvalid(wr_tvalid),
    .wr_tlast (wr_tlast),
    .wr_tready(wr_tready),
    .rd_tdata (rd_tdata),
    .rd_tvalid(rd_tvalid),
    .rd_tready(rd_tready),
    .rd_tlast (rd_tlast),
    .rd_sample(rd_sample),
    .rd_status(rd_status),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every popped word must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rd_tvalid && rd_tready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sb_pop: got word %h, required no word", {rd_tlast, rd_tdata});
      end else begin
        exp_word = sb.pop_front();
        if ({rd_tlast, rd_tdata} !== exp_word) begin
          n_fail++;
          $display("[TB] FAIL sb_word: got %h, required %h", {rd_tlast, rd_tdata}, exp_word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    wr_tdata  = d;
    wr_tvalid = 1'b1;
    wr_tlast  = last;
    tick();
    wr_tvalid = 1'b0;
    wr_tlast  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input logic push);
    if (push) sb.push_back({last, w});
    send_beat(w[31:24], 1'b0);
    send_beat(w[23:16], 1'b0);
    send_beat(w[15:8], 1'b0);
    send_beat(w[7:0], last);
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    rd_tready = 1'b1;
    while ((sb.size() != 0 || rd_tvalid) && cyc < 300) begin
      tick();
      cyc++;
    end
    rd_tready = 1'b0;
    n_checks++;
    if (sb.size() != 0 || rd_tvalid) begin
      n_fail++;
      $display("[TB] FAIL %s_drain: %0d words left, required 0", name, sb.size());
    end
    n_checks++;
    if (level !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL %s_level_empty: got %0d, required 0", name, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (rd_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tvalid: got %b, required 0", rd_tvalid); end
    n_checks++;
    if (rd_tlast !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tlast: got %b, required 0", rd_tlast); end
    n_checks++;
    if (rd_tdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_tdata: got %h, required 0", rd_tdata); end
    n_checks++;
    if (rd_status !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_status: got %h, required 0", rd_status); end
    n_checks++;
    if (level !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d, required 0", level); end
    n_checks++;
    if (wr_tready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_wr_tready: got %b, required 1", wr_tready); end
    rst = 1'b0;
    tick();
  endtask

  // Full word with tlast, then check show-ahead latency.
  task automatic test_full_word();
    send_word(32'h11223344, 1'b1, 1'b1);
    n_checks++;
    if (rd_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL latency_early: got tvalid %b, required 0", rd_tvalid); end
    tick();
    n_checks++;
    if (rd_tvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL latency_n2: got tvalid %b, required 1", rd_tvalid); end
    n_checks++;
    if (rd_tdata !== 32'h11223344) begin n_fail++; $display("[TB] FAIL head_data: got %h, required 11223344", rd_tdata); end
    n_checks++;
    if (rd_tlast !== 1'b1) begin n_fail++; $display("[TB] FAIL head_tlast: got %b, required 1", rd_tlast); end
    n_checks++;
    if (level !== 5'd1) begin n_fail++; $display("[TB] FAIL level_one: got %0d, required 1", level); end
    drain("full_word");
  endtask

  // Short packet padded with zeros, then a full word without tlast.
  task automatic test_partial();
    sb.push_back({1'b1, 32'hAABB0000});
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    send_word(32'h01020304, 1'b0, 1'b1);
    drain("partial");
  endtask

  task automatic test_overflow();
    rd_tready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      send_word({k[7:0], 24'hB0C0D0}, k[0], 1'b1);
      n_checks++;
      if (wr_tready !== (k <= 14)) begin
        n_fail++;
        $display("[TB] FAIL ovf_wr_tready_%0d: got %b, required %b", k, wr_tready, (k <= 14));
      end
    end
    send_word(32'hDEADBEEF, 1'b1, 1'b0);
    n_checks++;
    if (level !== 5'd16) begin n_fail++; $display("[TB] FAIL ovf_level: got %0d, required 16", level); end
    // A packet end while still above the resume level must not resume.
    send_beat(8'h77, 1'b1);
    rd_tready = 1'b1;
    repeat (12) tick();
    rd_tready = 1'b0;
    n_checks++;
    if (level !== 5'd4) begin n_fail++; $display("[TB] FAIL ovf_level_after_pop: got %0d, required 4", level); end
    n_checks++;
    if (wr_tready !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_still_drop: got wr_tready %b, required 0", wr_tready); end
    send_beat(8'hEE, 1'b0);
    send_beat(8'hFF, 1'b1);
    n_checks++;
    if (wr_tready !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_resume: got wr_tready %b, required 1", wr_tready); end
    n_checks++;
    if (level !== 5'd4) begin n_fail++; $display("[TB] FAIL ovf_resume_level: got %0d, required 4", level); end
    send_word(32'h5A5B5C5D, 1'b1, 1'b1);
    drain("overflow");
  endtask

  // Full FIFO with commit and pop in the same cycle.
  task automatic test_full_pop();
    for (int k = 0; k < 16; k++) send_word({8'h60, k[7:0], 16'h1234}, 1'b0, 1'b1);
    sb.push_back({1'b1, 32'hF00DCAFE});
    send_beat(8'hF0, 1'b0);
    send_beat(8'h0D, 1'b0);
    send_beat(8'hCA, 1'b0);
    rd_tready = 1'b1;
    send_beat(8'hFE, 1'b1);
    rd_tready = 1'b0;
    n_checks++;
    if (level !== 5'd16) begin n_fail++; $display("[TB] FAIL fullpop_level: got %0d, required 16", level); end
    rd_tready = 1'b1;
    repeat (12) tick();
    rd_tready = 1'b0;
    n_checks++;
    if (wr_tready !== 1'b1) begin n_fail++; $display("[TB] FAIL fullpop_pass: got wr_tready %b, required 1", wr_tready); end
    drain("full_pop");
  endtask

  // Streaming across several pointer wraps, then the recovery flag.
  task automatic test_stream_status();
    logic [31:0] w;
    logic        last;
    rd_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w    = $urandom;
      last = 1'($urandom_range(0, 1));
      send_word(w, last, 1'b1);
    end
    drain("stream");
    rd_sample = 1'b1;
    tick();
    rd_sample = 1'b0;
    n_checks++;
    if (rd_status[7] !== 1'b1) begin n_fail++; $display("[TB] FAIL status_underrun: got %b, required 1", rd_status[7]); end
    send_word(32'h12345678, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (rd_tvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL status_tvalid: got %b, required 1", rd_tvalid); end
    rd_sample = 1'b1;
    tick();
    rd_sample = 1'b0;
    n_checks++;
    if (rd_status[7] !== 1'b1) begin n_fail++; $display("[TB] FAIL status_preclear: got %b, required 1", rd_status[7]); end
    repeat (3) tick();
    rd_sample = 1'b1;
    tick();
    rd_sample = 1'b0;
    n_checks++;
    if (rd_status[7] !== 1'b0) begin n_fail++; $display("[TB] FAIL status_clean: got %b, required 0", rd_status[7]); end
    drain("status");
  endtask

  // Reset mid-word with words stored.
  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) send_word({8'h90, k[7:0], 16'hABCD}, 1'b0, 1'b0);
    send_beat(8'h71, 1'b0);
    send_beat(8'h72, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (level !== 5'd0) begin n_fail++; $display("[TB] FAIL rstmid_level: got %0d, required 0", level); end
    n_checks++;
    if (rd_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_tvalid: got %b, required 0", rd_tvalid); end
    send_word(32'hC0FFEE11, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (rd_tdata !== 32'hC0FFEE11) begin n_fail++; $display("[TB] FAIL rstmid_data: got %h, required c0ffee11", rd_tdata); end
    drain("reset_mid");
  endtask

  initial begin
    rst       = 1'b1;
    wr_tdata  = 8'h00;
    wr_tvalid = 1'b0;
    wr_tlast  = 1'b0;
    rd_tready = 1'b0;
    rd_sample = 1'b0;
    #1;
    test_reset();
    test_full_word();
    test_partial();
    test_overflow();
    test_full_pop();
    test_stream_status();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_pack_fifo.md
STREAM_PACK_FIFO -- requirements
Module: stream_pack_fifo

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 WR_WIDTH, 8, input beat width in bits.
 RATIO, 4, input beats per stored word; RD_WIDTH = WR_WIDTH*RATIO.
 DEPTH, 1024, stored words; power of 2, at least 16.
 RESUME_LEVEL, DEPTH/4, level at or below which the block leaves DROP.
 READY_MARGIN, 8, free-word margin for advisory wr_tready.
 STATUS_BITS, 7, width of the sampled level field.
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk  in  1  sole clock.
 rst  in  1  synchronous, active-high reset.
 wr_tdata  in  WR_WIDTH  input beat.
 wr_tvalid  in  1  beat present; consumed the same cycle.
 wr_tlast  in  1  last beat of a packet.
 wr_tready  out  1  advisory backpressure.
 rd_tdata  out  RD_WIDTH  show-ahead head word.
 rd_tvalid  out  1  head word valid.
 rd_tready  in  1  pop head word.
 rd_tlast  out  1  head word ends a packet.
 rd_sample  in  1  status capture strobe.
 rd_status  out  STATUS_BITS+1  {recovery flag, sampled level MSBs}.
 level  out  log2(DEPTH)+1  words stored and not yet popped.

Function
REQ-003 The block SHALL treat every wr_tvalid beat as consumed regardless of wr_tready; wr_tready SHALL equal (state==PASS) & (level <= DEPTH-READY_MARGIN).
REQ-004 The block SHALL pack beats into a RD_WIDTH word, first beat in the MSBs.
REQ-005 A word SHALL commit on the RATIO-th beat or on any wr_tlast beat; a partial word SHALL be zero-padded in its LSBs and stored with tlast=1.
REQ-006 A commit SHALL succeed if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
REQ-007 The FSM SHALL have states PASS and DROP; reset state is PASS.
REQ-008 PASS->DROP SHALL occur on a commit that cannot succeed; that word and the partial pack SHALL be discarded.
REQ-009 In DROP all beats SHALL be discarded; DROP->PASS SHALL occur on a wr_tlast beat with level<=RESUME_LEVEL, and that beat SHALL be discarded.
REQ-010 The pack counter SHALL be zero after every commit, discard and DROP->PASS transition.
REQ-011 Read SHALL be show-ahead: a word committed to an empty FIFO in cycle N SHALL give rd_tvalid=1 in cycle N+2.
REQ-012 A pop SHALL occur when rd_tvalid & rd_tready; rd_tready while rd_tvalid=0 SHALL be ignored; with sustained rd_tready, one word per cycle SHALL be delivered.
REQ-013 level SHALL be +1 per successful commit and -1 per pop; a simultaneous commit and pop SHALL leave it unchanged; it SHALL never exceed DEPTH or go below 0.
REQ-014 Pointers SHALL wrap modulo DEPTH with no data loss or reorder.
REQ-015 The recovery flag SHALL be set in any cycle where rd_tvalid=0 or state==DROP; rd_sample SHALL capture the top STATUS_BITS of the level, clear the flag, and latch its pre-clear value into rd_status; rd_sample takes priority over a set in the same cycle.

Reset
REQ-016 rst SHALL empty the FIFO and zero the pack register, pack counter, pointers, level and flags, force state PASS, and drive rd_tvalid=0, rd_tlast=0, rd_tdata=0, rd_status=0.
REQ-017 rst asserted mid-packet SHALL discard the partial pack and all stored words; the first post-reset beat SHALL start a new word.
REQ-018 RAM contents need not be cleared.

Structure
REQ-019 Shared package fifo_pkg SHALL hold the PASS/DROP state enum and a clog2-based address-width function.
REQ-020 Storage SHALL be one sub-module, sdp_ram: single-clock simple dual-port memory with registered read, RD_WIDTH+1 bits wide (data plus tlast).

Verification (WR_WIDTH=8, RATIO=4, DEPTH=16, RESUME_LEVEL=4, READY_MARGIN=2)
REQ-021 Beats 11,22,33,44 with wr_tlast on 44 -> rd_tdata=0x11223344, rd_tlast=1, rd_tvalid at commit+2.
REQ-022 Beats AA,BB with wr_tlast on BB -> rd_tdata=0xAABB0000, rd_tlast=1.
REQ-023 rd_tready=0 and 17 four-beat words written -> level=16, wr_tready=0 from level 15, 17th word dropped, state=DROP; pop 12 words then send a tlast beat -> state=PASS; the next packet is stored intact.
REQ-024 level=16 with a 17th commit and a pop in the same cycle -> commit accepted, level stays 16, state stays PASS.
REQ-025 Continuous write and read of 100 words -> in-order output across pointer wrap; rd_sample after an underrun -> rd_status[7]=1 one sample later, then 0 after a clean interval.
REQ-026 rst after 2 beats of a word with 5 words stored -> level=0, rd_tvalid=0; a new 4-beat word is output unchanged.
